// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   DIGITS     : number of scanned digit positions on the board
//   SEG_OFF    : all segments dark, bit order {CA..CG} with CA in the MSB
//   hex_to_seg : active-low segment pattern for one hex nibble
package seg7_pkg;

  localparam int DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {a,b,c,d,e,f,g}. The letters b and d use lowercase shapes so
  // they cannot be confused with 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   hex_i : 4-bit hex digit
//   seg_o : active-low segments {CA..CG}, CA in the MSB
module hex7seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// A shadow image (hex nibbles, decimal points, digit enables) is scanned one
// digit per slot; a new image is staged through LOAD and committed only at
// the end of a frame so a frame never shows a mix of two images.
//   CLK100MHZ, RST    : clock, synchronous active-high reset
//   DATA_IN, DP_IN    : hex image (digit i = DATA_IN[4i+3:4i]) and DP enables
//   EN_MASK, LOAD     : digit enables, capture strobe for the pending image
//   BUSY, LOAD_ACK    : pending image waiting, one-cycle commit pulse
//   AN, CA..CG, DP    : registered, active-low display pins
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic [31:0] DATA_IN,
  input  logic [7:0]  DP_IN,
  input  logic [7:0]  EN_MASK,
  input  logic        LOAD,
  output logic        BUSY,
  output logic        LOAD_ACK,
  output logic [7:0]  AN,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0] presc_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   shadow_data_q, pend_data_q;
  logic [7:0]    shadow_dp_q, pend_dp_q;
  logic [7:0]    shadow_en_q, pend_en_q;
  logic          busy_q, ack_q;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic          tick, frame_end, slot_lit;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign tick      = (presc_q == PRESC_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // The first BLANK_CYC clocks of every slot keep all anodes off so the
  // previous digit's segment pattern cannot ghost onto the new digit.
  assign slot_lit = (presc_q >= BLANK_END) && shadow_en_q[idx_q];

  assign nibble = shadow_data_q[{idx_q, 2'b00} +: 4];

  hex7seg_decoder u_dec (
    .hex_i (nibble),
    .seg_o (seg_dec)
  );

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
      assign an_d[gi] = ~(slot_lit && (idx_q == IW'(gi)));
    end
  endgenerate

  assign seg_d = slot_lit ? seg_dec : SEG_OFF;
  assign dp_d  = slot_lit ? ~shadow_dp_q[idx_q] : 1'b1;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      presc_q       <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_en_q   <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      an_q          <= 8'hFF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end

      ack_q <= frame_end && busy_q;
      if (frame_end && busy_q) begin
        shadow_data_q <= pend_data_q;
        shadow_dp_q   <= pend_dp_q;
        shadow_en_q   <= pend_en_q;
        busy_q        <= 1'b0;
      end

      // Placed after the commit so a LOAD on the frame-end edge re-arms BUSY
      // while the commit above still consumes the previous pending image.
      if (LOAD) begin
        pend_data_q <= DATA_IN;
        pend_dp_q   <= DP_IN;
        pend_en_q   <= EN_MASK;
        busy_q      <= 1'b1;
      end

      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign AN       = an_q;
  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign DP       = dp_q;
  assign BUSY     = busy_q;
  assign LOAD_ACK = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 8 * CLK_DIV;

  logic        CLK100MHZ;
  logic        RST;
  logic [31:0] DATA_IN;
  logic [7:0]  DP_IN;
  logic [7:0]  EN_MASK;
  logic        LOAD;
  logic        BUSY, LOAD_ACK;
  logic [7:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;

  seg7_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .DATA_IN   (DATA_IN),
    .DP_IN     (DP_IN),
    .EN_MASK   (EN_MASK),
    .LOAD      (LOAD),
    .BUSY      (BUSY),
    .LOAD_ACK  (LOAD_ACK),
    .AN        (AN),
    .CA        (CA),
    .CB        (CB),
    .CC        (CC),
    .CD        (CD),
    .CE        (CE),
    .CF        (CF),
    .CG        (CG),
    .DP        (DP)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_seen = 0;
  int unsigned drv_edge = 0;
  int unsigned mon_edge = 0;

  // Reference model: time since reset as one frame-position counter
  int          m_cyc;
  logic [31:0] m_sh_data, m_pd_data;
  logic [7:0]  m_sh_dp, m_pd_dp, m_sh_en, m_pd_en;
  logic        m_busy;

  // Segment shapes written as the set of lit segment letters.
  function automatic logic [6:0] seg_ref(input int h);
    string lit;
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      0: lit = "abcdef";   1: lit = "bc";       2: lit = "abdeg";   3: lit = "abcdg";
      4: lit = "bcfg";     5: lit = "acdfg";    6: lit = "acdefg";  7: lit = "abc";
      8: lit = "abcdefg";  9: lit = "abcdfg";   10: lit = "abcefg"; 11: lit = "cdefg";
      12: lit = "adef";    13: lit = "bcdeg";   14: lit = "adefg";  default: lit = "aefg";
    endcase
    for (int k = 0; k < lit.len(); k++) s[6 - (int'(lit[k]) - 97)] = 1'b0;
    return s;
  endfunction

  task automatic step(input bit r, input bit ld, input logic [31:0] d,
                      input logic [7:0] p, input logic [7:0] e);
    exp_t x;
    int pos, dig;
    bit lit;
    RST = r; LOAD = ld; DATA_IN = d; DP_IN = p; EN_MASK = e;
    drv_edge++;
    x.edge_no = drv_edge;
    if (r) begin
      x.an = 8'hFF; x.seg = 7'h7F; x.dp = 1'b1; x.busy = 1'b0; x.ack = 1'b0;
      m_cyc = 0; m_sh_data = '0; m_sh_dp = '0; m_sh_en = '0; m_busy = 1'b0;
      $display("edge %0d: reset", drv_edge);
    end else begin
      pos = m_cyc % CLK_DIV;
      dig = m_cyc / CLK_DIV;
      lit = (pos >= BLANK_CYC) && m_sh_en[dig];
      x.an  = lit ? ~(8'h01 << dig) : 8'hFF;
      x.seg = lit ? seg_ref(int'((m_sh_data >> (4 * dig)) & 32'hF)) : 7'h7F;
      x.dp  = lit ? ~m_sh_dp[dig] : 1'b1;
      x.ack = (m_cyc == FRAME - 1) && m_busy;
      if (x.ack) begin
        m_sh_data = m_pd_data; m_sh_dp = m_pd_dp; m_sh_en = m_pd_en; m_busy = 1'b0;
      end
      if (ld) begin
        m_pd_data = d; m_pd_dp = p; m_pd_en = e; m_busy = 1'b1;
        $display("edge %0d: load data=%h dp=%h en=%h", drv_edge, d, p, e);
      end
      x.busy = m_busy;
      m_cyc = (m_cyc + 1) % FRAME;
    end
    exp_q.push_back(x);
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every output edge is a presented response; compare against the
  // expectation tagged for that edge.
  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d: got %h, required %h", name, mon_edge, act, req);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge CLK100MHZ);
      mon_edge++;
      @(negedge CLK100MHZ);
      while (exp_q.size() > 0 && exp_q[0].edge_no < mon_edge) begin
        x = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL stale expectation for edge %0d at edge %0d", x.edge_no, mon_edge);
      end
      if (exp_q.size() > 0 && exp_q[0].edge_no == mon_edge) begin
        x = exp_q.pop_front();
        cmp("AN", AN, x.an);
        cmp("SEG", {1'b0, CA, CB, CC, CD, CE, CF, CG}, {1'b0, x.seg});
        cmp("DP", {7'b0, DP}, {7'b0, x.dp});
        cmp("BUSY", {7'b0, BUSY}, {7'b0, x.busy});
        cmp("LOAD_ACK", {7'b0, LOAD_ACK}, {7'b0, x.ack});
        if (LOAD_ACK === 1'b1) begin
          ack_seen++;
          $display("edge %0d: load ack", mon_edge);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks0;
    m_cyc = 0; m_sh_data = '0; m_pd_data = '0; m_sh_dp = '0; m_pd_dp = '0;
    m_sh_en = '0; m_pd_en = '0; m_busy = 1'b0;

    // 1: reset, then a blank frame with an all-zero enable mask
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, '0);
    idle(FRAME);

    // 2: full image, single ACK, then scanned display
    acks0 = ack_seen;
    step(1'b0, 1'b1, 32'h76543210, 8'h01, 8'hFF);
    idle(2 * FRAME + 10);
    check_val("ack_count_first_load", ack_seen - acks0, 1);

    // 3: upper four digits disabled
    step(1'b0, 1'b1, 32'h89ABCDEF, 8'hA5, 8'h0F);
    idle(2 * FRAME + 10);

    // 4: two loads in one frame, last one wins with exactly one ACK
    while (m_cyc != 0) idle(1);
    acks0 = ack_seen;
    step(1'b0, 1'b1, 32'h11111111, 8'h00, 8'hFF);
    idle(5);
    step(1'b0, 1'b1, 32'hAAAAAAAA, 8'h00, 8'hFF);
    idle(2 * FRAME + 10);
    check_val("ack_count_double_load", ack_seen - acks0, 1);

    // 5: load on the frame-end edge while idle commits a full frame later
    while (m_cyc != FRAME - 1) idle(1);
    acks0 = ack_seen;
    step(1'b0, 1'b1, 32'h0F1E2D3C, 8'h3C, 8'hFF);
    idle(FRAME - 2);
    check_val("ack_early_frame_end_load", ack_seen - acks0, 0);
    idle(FRAME);
    check_val("ack_count_frame_end_load", ack_seen - acks0, 1);

    // 6: reset mid-frame discards the pending image
    while (m_cyc != 20) idle(1);
    step(1'b0, 1'b1, 32'h12345678, 8'hFF, 8'hFF);
    idle(6);
    step(1'b1, 1'b0, '0, '0, '0);
    acks0 = ack_seen;
    idle(2 * FRAME + 2);
    check_val("ack_after_reset", ack_seen - acks0, 0);

    // 7: randomized loads and occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0),
           $urandom, 8'($urandom), 8'($urandom));
    end
    idle(2 * FRAME);

    @(negedge CLK100MHZ);
    #1;
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
